// File: rtl/seg_display_ctrl.sv
// Binary to seven-segment controller: hex or double-dabble decimal.
// Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module seg_display_ctrl #(
  parameter int BIN_W      = 8,
  parameter int DIGITS     = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [8*DIGITS-1:0]   o_seg
);

  localparam int BW = 4*DIGITS + 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct nibbles, then shift the new bit in.
  function automatic logic [BW-1:0] dabble(
    input logic [BW-1:0] b,
    input logic          in
  );
    logic [BW-1:0] a;
    a = b;
    for (int n = 0; n < BW/4; n++)
      if (a[4*n +: 4] >= 4'd5) a[4*n +: 4] = a[4*n +: 4] + 4'd3;
    return {a[BW-2:0], in};
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [5:0]  LAST  = 6'(BIN_W - 1);
  localparam logic [8*DIGITS-1:0] SEG_OFF =
    {(8*DIGITS){ACTIVE_LOW != 0}};

  logic [1:0]          state;
  logic [5:0]          cnt;
  logic [BIN_W-1:0]    val;
  logic [BIN_W-1:0]    sh;
  logic [BW-1:0]       bcd;
  logic                mode;
  logic [63:0]         ext;
  logic [8*DIGITS-1:0] seg_n;
  logic                ovf_n;
  logic [3:0]          nib;
  logic [7:0]          glyph;
`ifdef LEADING_ZERO_BLANK_EN
  logic                lead;
`endif

  assign ext = 64'(val);

  always_comb begin
    seg_n = '0;
    nib   = '0;
    glyph = '0;
    ovf_n = mode ? (ext >= LIMIT)
                 : ((ext >> (4*DIGITS)) != 64'd0);
`ifdef LEADING_ZERO_BLANK_EN
    lead  = 1'b1;
`endif
    for (int k = DIGITS-1; k >= 0; k--) begin
      nib   = mode ? bcd[4*k +: 4] : ext[4*k +: 4];
      glyph = {1'b0, seg7(nib)};
`ifdef LEADING_ZERO_BLANK_EN
      // Digit 0 is never blanked so zero still reads "0".
      if (lead && nib == 4'd0 && k != 0) glyph = 8'h00;
      if (nib != 4'd0) lead = 1'b0;
`else
`endif
      seg_n[8*k +: 8] = (ACTIVE_LOW != 0) ? ~glyph : glyph;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      val        <= '0;
      sh         <= '0;
      bcd        <= '0;
      mode       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_seg      <= SEG_OFF;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            val    <= i_bin;
            sh     <= i_bin;
            mode   <= i_mode;
            cnt    <= '0;
            bcd    <= '0;
            o_busy <= 1'b1;
            state  <= i_mode ? SHIFT : UPDATE;
          end
        end
        SHIFT: begin
          bcd <= dabble(bcd, sh[BIN_W-1]);
          sh  <= sh << 1;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= UPDATE;
        end
        UPDATE: begin
          o_seg      <= seg_n;
          o_overflow <= ovf_n;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
